bullet_scheduler: RTL and testbench
===================================

// Module: bullet_scheduler
// PURPOSE
//  Owns a fixed pool of bullet slots fired from the player ship. Latches fire requests,
//  allocates free slots at the ship nose, steps every live bullet upward once per movement
//  tick, frees slots that leave the field, and produces a per-pixel bullet colour.
//  Sits beside the ship sprite. Its colour output is merged with ship_color in the display mux.
// PARAMETERS
//  NUM_BULLETS   4          slot count (1..8)
//  TICK_BITS     19         tick fires when counter[TICK_BITS]==1; period = 2^TICK_BITS+1 clocks
//  SPEED         4          pixels a bullet moves up per tick
//  COOLDOWN      8          ticks between successful spawns
//  SHIP_SIZE     64         ship sprite edge, used to centre spawn x
//  BULLET_W      4          bullet width (pixels)
//  BULLET_H      8          bullet height (pixels)
//  BULLET_COLOR  24'hFFFF00 RGB drawn for bullet pixels
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high; clears all state immediately
//  fire          in   1   fire button level (synchronous to clock)
//  ship_hor_pos  in   12  ship left x (registered by ship block)
//  ship_ver_pos  in   11  ship top y
//  display_col   in   12  current scan column
//  display_row   in   11  current scan row
//  bullet_color  out  25  {BULLET_COLOR,1'b1} on bullet pixel, else 25'b0
//  active_mask   out  NUM_BULLETS  bit i = slot i live
//  busy          out  1   high while FSM is in UPDATE or SPAWN
//  fire_dropped  out  1   one-clock pulse: pending fire discarded, pool full
// BEHAVIOUR
//  Reset values: all outputs 0, counter 0, cooldown 0, fire_pending 0, all slots free, FSM=IDLE.
//  Tick: counter increments each clock. When counter[TICK_BITS]==1, counter<=0 and tick<=1
//   for one clock. Any tick arriving outside IDLE is ignored.
//  Fire: fire_pending<=1 on a rising edge of fire (registered previous value).
//   Further edges are ignored while fire_pending is set.
//  FSM IDLE: on tick -> UPDATE with idx=0.
//  FSM UPDATE, one slot per clock, idx 0..NUM_BULLETS-1:
//   if slot idx is live and y<SPEED, the slot is freed; otherwise y<=y-SPEED. x is unchanged.
//   After idx=NUM_BULLETS-1 -> SPAWN. UPDATE lasts exactly NUM_BULLETS clocks.
//  FSM SPAWN, 1 clock, then -> IDLE:
//   Case 1: fire_pending and cooldown==0 and a free slot exists.
//    The lowest-index free slot goes live.
//    x = ship_hor_pos + SHIP_SIZE/2 - BULLET_W/2 (12-bit, wraps mod 4096).
//    y = ship_ver_pos - BULLET_H, clamped to 0 when ship_ver_pos < BULLET_H.
//    cooldown<=COOLDOWN, fire_pending<=0.
//   Case 2: fire_pending and cooldown==0 and no free slot.
//    fire_pending<=0 and fire_dropped pulses.
//   Case 3: fire_pending and cooldown!=0. fire_pending is held.
//   In every case, if cooldown!=0 and no spawn occurred, cooldown<=cooldown-1.
//  Freeing happens only in UPDATE and allocation only in SPAWN, so the two never collide.
//   A slot freed in UPDATE is available in the same tick's SPAWN.
//  Pixel: bullet_color registered, 1 clock latency from display_col/row.
//   Hit = any live slot with x<=col<=x+BULLET_W-1 and y<=row<=y+BULLET_H-1.
//   Overlapping bullets give the same colour.
//  active_mask reflects slot state registers directly (no extra latency).
//  Requirement: 2^TICK_BITS+1 > NUM_BULLETS+2, which guarantees IDLE before each tick.
//  Reset asserted mid-UPDATE/SPAWN: everything clears at once and no partial spawn survives.
// TESTING  (TICK_BITS=3 -> tick every 9 clocks, NUM_BULLETS=4, COOLDOWN=2)
//  1. Hold reset, then release -> all outputs 0; first tick 9 clocks after release.
//     busy is high for exactly 5 clocks after each tick.
//  2. Ship at (100,200), one fire edge -> after next SPAWN active_mask=4'b0001, slot0=(130,192).
//     Following tick -> y=188.
//  3. Three fire edges, one per tick, with COOLDOWN=2 -> spawns on ticks 1 and 4 only.
//     The pending fire is held through ticks 2-3.
//  4. Four live slots plus a fire with cooldown 0 -> fire_dropped pulses 1 clock.
//     active_mask stays 4'b1111.
//  5. Slot at y=3 with SPEED=4 -> freed in UPDATE. A pending fire in the same tick reuses that slot.
//  6. Bullet at (130,192): col=130,row=192 -> bullet_color={24'hFFFF00,1} one clock later.
//     col=134 -> 0. Asserting reset during UPDATE -> active_mask=0 immediately.

Source files
------------

// File: rtl/bullet_scheduler.sv
// Bullet pool for the player ship: latches fire requests, spawns bullets at the ship nose,
// moves live bullets upward once per movement tick and renders their pixels.
module bullet_scheduler #(
  parameter int          NUM_BULLETS  = 4,
  parameter int          TICK_BITS    = 19,
  parameter int          SPEED        = 4,
  parameter int          COOLDOWN     = 8,
  parameter int          SHIP_SIZE    = 64,
  parameter int          BULLET_W     = 4,
  parameter int          BULLET_H     = 8,
  parameter logic [23:0] BULLET_COLOR = 24'hFFFF00
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fire,
  input  logic [11:0]            ship_hor_pos,
  input  logic [10:0]            ship_ver_pos,
  input  logic [11:0]            display_col,
  input  logic [10:0]            display_row,
  output logic [24:0]            bullet_color,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic                   busy,
  output logic                   fire_dropped
);

  localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

  state_t                 state, state_next;
  logic [TICK_BITS:0]     tick_count;
  logic                   tick;
  logic                   fire_prev;
  logic                   fire_pending;
  logic [CD_W-1:0]        cooldown;
  logic [IDX_W-1:0]       idx;
  logic [NUM_BULLETS-1:0] live;
  logic [11:0]            pos_x [NUM_BULLETS];
  logic [10:0]            pos_y [NUM_BULLETS];
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic                   spawn_try;
  logic                   do_spawn;
  logic                   do_drop;
  logic [11:0]            spawn_x;
  logic [10:0]            spawn_y;
  logic                   hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_count <= '0;
      tick       <= 1'b0;
    end else if (tick_count[TICK_BITS]) begin
      tick_count <= '0;
      tick       <= 1'b1;
    end else begin
      tick_count <= tick_count + 1'b1;
      tick       <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A tick seen outside IDLE is simply dropped by this transition table.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = UPDATE;
      UPDATE:  if (idx == IDX_W'(NUM_BULLETS - 1)) state_next = SPAWN;
      SPAWN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_try = (state == SPAWN) && fire_pending && (cooldown == '0);
  assign do_spawn  = spawn_try && free_found;
  assign do_drop   = spawn_try && !free_found;
  assign spawn_x   = ship_hor_pos + 12'(SHIP_SIZE / 2 - BULLET_W / 2);
  assign spawn_y   = (ship_ver_pos < 11'(BULLET_H)) ? '0 : ship_ver_pos - 11'(BULLET_H);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fire_prev    <= 1'b0;
      fire_pending <= 1'b0;
      cooldown     <= '0;
      idx          <= '0;
      fire_dropped <= 1'b0;
    end else begin
      fire_prev    <= fire;
      fire_dropped <= do_drop;
      if (spawn_try)
        fire_pending <= 1'b0;
      else if (fire && !fire_prev)
        fire_pending <= 1'b1;
      if (do_spawn)
        cooldown <= CD_W'(COOLDOWN);
      else if ((state == SPAWN) && (cooldown != '0))
        cooldown <= cooldown - 1'b1;
      if (state == UPDATE) idx <= idx + 1'b1;
      else                 idx <= '0;
    end
  end

  // Freeing only in UPDATE and allocation only in SPAWN keeps slot writes exclusive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else if (state == UPDATE) begin
      if (live[idx]) begin
        if (pos_y[idx] < 11'(SPEED)) live[idx] <= 1'b0;
        else                         pos_y[idx] <= pos_y[idx] - 11'(SPEED);
      end
    end else if (do_spawn) begin
      live[free_idx]  <= 1'b1;
      pos_x[free_idx] <= spawn_x;
      pos_y[free_idx] <= spawn_y;
    end
  end

  // Extra top bit keeps the right/bottom edge compare from wrapping near the field edge.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (live[i] &&
          ({1'b0, display_col} >= {1'b0, pos_x[i]}) &&
          ({1'b0, display_col} <= {1'b0, pos_x[i]} + 13'(BULLET_W - 1)) &&
          ({1'b0, display_row} >= {1'b0, pos_y[i]}) &&
          ({1'b0, display_row} <= {1'b0, pos_y[i]} + 12'(BULLET_H - 1)))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    bullet_color <= '0;
    else if (hit) bullet_color <= {BULLET_COLOR, 1'b1};
    else          bullet_color <= '0;
  end

  assign active_mask = live;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_bullet_scheduler.sv
// Scoreboard bench for bullet_scheduler: per-tick mask/drop expectations and pixel
// expectations are queued by the stimulus and popped by an independent monitor.
module tb_bullet_scheduler;

  localparam logic [24:0] HIT = {24'hFFFF00, 1'b1};

  typedef struct packed {
    logic [3:0] mask;
    logic       drop;
  } tick_exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        fire;
  logic [11:0] ship_hor_pos;
  logic [10:0] ship_ver_pos;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic [24:0] bullet_color;
  logic [3:0]  active_mask;
  logic        busy;
  logic        fire_dropped;

  int          checks = 0;
  int          errors = 0;
  tick_exp_t   tick_q[$];
  logic [24:0] pix_q[$];
  tick_exp_t   tick_e;
  logic [24:0] pix_e;
  logic        pix_req = 1'b0;
  logic        pix_req_d = 1'b0;
  logic        busy_prev = 1'b0;
  int          busy_len = 0;
  int          latency;

  bullet_scheduler #(
    .NUM_BULLETS (4),
    .TICK_BITS   (3),
    .SPEED       (4),
    .COOLDOWN    (2),
    .SHIP_SIZE   (64),
    .BULLET_W    (4),
    .BULLET_H    (8),
    .BULLET_COLOR(24'hFFFF00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fire        (fire),
    .ship_hor_pos(ship_hor_pos),
    .ship_ver_pos(ship_ver_pos),
    .display_col (display_col),
    .display_row (display_row),
    .bullet_color(bullet_color),
    .active_mask (active_mask),
    .busy        (busy),
    .fire_dropped(fire_dropped)
  );

  always #5 clock = ~clock;

  always @(posedge clock) pix_req_d <= pix_req;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a busy falling edge marks the end of a tick's SPAWN; a delayed request marks pixel data.
  always @(negedge clock) begin
    if (reset) begin
      busy_len  = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (busy_prev) begin
        check_output("busy_len", busy_len, 5);
        if (tick_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tick_unexpected: tick ended with mask 0x%0h, no expectation queued", active_mask);
        end else begin
          tick_e = tick_q.pop_front();
          check_output("tick_mask", active_mask, tick_e.mask);
          check_output("tick_drop", fire_dropped, tick_e.drop);
        end
        busy_len = 0;
      end
      if (fire_dropped && !(busy_prev && !busy)) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_drop: fire_dropped=1 outside the post-SPAWN clock, expected 0");
      end
      busy_prev = busy;
    end
    if (pix_req_d) begin
      if (pix_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL pix_unexpected: colour 0x%0h, no expectation queued", bullet_color);
      end else begin
        pix_e = pix_q.pop_front();
        check_output("pixel", bullet_color, pix_e);
      end
    end
  end

  task automatic wait_busy(input logic level, input int limit);
    int n = 0;
    while (busy !== level && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy !== level) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_busy: busy=%0b after %0d clocks, expected %0b", busy, limit, level);
    end
  endtask

  task automatic next_tick(input logic [3:0] mask, input logic drop);
    tick_q.push_back(tick_exp_t'{mask: mask, drop: drop});
    wait_busy(1'b1, 40);
    wait_busy(1'b0, 20);
  endtask

  task automatic apply_stimulus(input logic [11:0] col, input logic [10:0] row, input logic is_hit);
    display_col = col;
    display_row = row;
    pix_req     = 1'b1;
    pix_q.push_back(is_hit ? HIT : 25'd0);
    @(posedge clock); #1;
    pix_req = 1'b0;
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    @(posedge clock); #1;
    fire = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    fire         = 1'b0;
    ship_hor_pos = 12'd100;
    ship_ver_pos = 11'd200;
    display_col  = '0;
    display_row  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_mask", active_mask, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_drop", fire_dropped, 0);
    check_output("rst_color", bullet_color, 0);
    reset = 1'b0;

    // Tick registers on the 9th edge after release, UPDATE shows on the 10th.
    tick_q.push_back(tick_exp_t'{mask: 4'b0000, drop: 1'b0});
    latency = 0;
    while (busy !== 1'b1 && latency < 30) begin
      @(posedge clock); #1;
      latency++;
    end
    check_output("first_tick_latency", latency, 10);
    wait_busy(1'b0, 20);

    $display("[TB] single spawn and movement");
    fire_pulse();
    next_tick(4'b0001, 1'b0);
    apply_stimulus(12'd130, 11'd192, 1'b1);
    apply_stimulus(12'd134, 11'd192, 1'b0);
    apply_stimulus(12'd133, 11'd199, 1'b1);
    apply_stimulus(12'd129, 11'd199, 1'b0);
    fire_pulse();
    next_tick(4'b0001, 1'b0);
    apply_stimulus(12'd130, 11'd188, 1'b1);
    apply_stimulus(12'd130, 11'd187, 1'b0);
    apply_stimulus(12'd130, 11'd195, 1'b1);
    apply_stimulus(12'd130, 11'd196, 1'b0);

    $display("[TB] cooldown holds the pending fire");
    fire_pulse();
    next_tick(4'b0001, 1'b0);
    next_tick(4'b0011, 1'b0);
    apply_stimulus(12'd131, 11'd192, 1'b1);
    apply_stimulus(12'd130, 11'd180, 1'b1);
    apply_stimulus(12'd130, 11'd188, 1'b0);

    $display("[TB] fill the pool and drop");
    fire_pulse();
    next_tick(4'b0011, 1'b0);
    next_tick(4'b0011, 1'b0);
    next_tick(4'b0111, 1'b0);
    fire_pulse();
    next_tick(4'b0111, 1'b0);
    next_tick(4'b0111, 1'b0);
    next_tick(4'b1111, 1'b0);
    fire_pulse();
    next_tick(4'b1111, 1'b0);
    next_tick(4'b1111, 1'b0);
    next_tick(4'b1111, 1'b1);
    next_tick(4'b1111, 1'b0);

    $display("[TB] reset during UPDATE");
    wait_busy(1'b1, 40);
    check_output("mask_before_reset", active_mask, 4'b1111);
    reset = 1'b1;
    #1;
    check_output("async_rst_mask", active_mask, 0);
    check_output("async_rst_busy", busy, 0);
    @(posedge clock); #1;
    check_output("rst_hold_color", bullet_color, 0);
    check_output("rst_hold_drop", fire_dropped, 0);
    ship_hor_pos = 12'd100;
    ship_ver_pos = 11'd19;
    @(posedge clock); #1;
    reset = 1'b0;

    $display("[TB] slot freed at the top is reused in the same tick");
    fire_pulse();
    next_tick(4'b0001, 1'b0);
    apply_stimulus(12'd130, 11'd11, 1'b1);
    apply_stimulus(12'd130, 11'd18, 1'b1);
    apply_stimulus(12'd130, 11'd19, 1'b0);
    apply_stimulus(12'd130, 11'd10, 1'b0);
    fire_pulse();
    next_tick(4'b0001, 1'b0);
    next_tick(4'b0001, 1'b0);
    apply_stimulus(12'd130, 11'd3, 1'b1);
    apply_stimulus(12'd130, 11'd10, 1'b1);
    apply_stimulus(12'd130, 11'd11, 1'b0);
    ship_hor_pos = 12'd200;
    ship_ver_pos = 11'd100;
    next_tick(4'b0001, 1'b0);
    apply_stimulus(12'd230, 11'd92, 1'b1);
    apply_stimulus(12'd130, 11'd3, 1'b0);
    apply_stimulus(12'd233, 11'd99, 1'b1);
    apply_stimulus(12'd234, 11'd99, 1'b0);

    $display("[TB] x wrap and y clamp at the field edge");
    fire_pulse();
    next_tick(4'b0001, 1'b0);
    next_tick(4'b0001, 1'b0);
    ship_hor_pos = 12'd4080;
    ship_ver_pos = 11'd5;
    next_tick(4'b0011, 1'b0);
    apply_stimulus(12'd14, 11'd0, 1'b1);
    apply_stimulus(12'd17, 11'd7, 1'b1);
    apply_stimulus(12'd18, 11'd0, 1'b0);
    apply_stimulus(12'd14, 11'd8, 1'b0);
    next_tick(4'b0001, 1'b0);

    repeat (5) @(posedge clock);
    #1;
    check_output("tick_q_drained", tick_q.size(), 0);
    check_output("pix_q_drained", pix_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
